// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative 32-bit restoring radix-2 divider with stream handshake,
//            returning {quotient, remainder}. Optional DIV_ZERO_FAST_EN
//            shortcut sends divide-by-zero straight to DONE.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int SIGNED = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_dividend_tvalid,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_dividend_tready,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] tdata_q, tdata_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic        q_bit;
    logic [31:0] rem_next, quo_next;
`ifdef DIV_ZERO_FAST_EN
    logic        div_zero;
`endif

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        accept = (state_q == ST_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
        a_neg  = (SIGNED != 0) && s_axis_dividend_tdata[31];
        b_neg  = (SIGNED != 0) && s_axis_divisor_tdata[31];
        a_mag  = neg_if(a_neg, s_axis_dividend_tdata);
        b_mag  = neg_if(b_neg, s_axis_divisor_tdata);
`ifdef DIV_ZERO_FAST_EN
        div_zero = (s_axis_divisor_tdata == 32'd0);
`endif
        // Dividend register doubles as the quotient shift register: its MSB
        // feeds the partial remainder while quotient bits enter at the LSB.
        shifted  = {rem_q, dvd_q[31]};
        q_bit    = (shifted >= {1'b0, dsr_q});
        rem_next = q_bit ? (shifted[31:0] - dsr_q) : shifted[31:0];
        quo_next = {dvd_q[30:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            dvd_q   <= 32'd0;
            dsr_q   <= 32'd0;
            rem_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            tdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            tdata_q <= tdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = div_zero ? ST_DONE : ST_CALC;
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        tdata_d = tdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dvd_d   = a_mag;
                    dsr_d   = b_mag;
                    rem_d   = 32'd0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    cnt_d   = 6'd0;
`ifdef DIV_ZERO_FAST_EN
                    if (div_zero) begin
                        tdata_d = {neg_if(a_neg ^ b_neg, 32'hFFFF_FFFF), neg_if(a_neg, a_mag)};
                    end
`endif
                end
            end
            ST_CALC: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q + 6'd1;
                // Result is registered on the final iteration so it is stable in DONE.
                if (cnt_q == LAST_ITER) begin
                    tdata_d = {neg_if(q_neg_q, quo_next), neg_if(r_neg_q, rem_next)};
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        s_axis_dividend_tready = (state_q == ST_IDLE);
        s_axis_divisor_tready  = (state_q == ST_IDLE);
        m_axis_dout_tvalid     = (state_q == ST_DONE);
        m_axis_dout_tdata      = tdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed self-checking bench for div_unit, signed and unsigned
//            instances side by side. Honours DIV_ZERO_FAST_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] a_data, b_data;
    logic        a_vld, b_vld;

    logic        s_rdy_a, s_rdy_b, s_vld;
    logic [63:0] s_data;
    logic        u_rdy_a, u_rdy_b, u_vld;
    logic [63:0] u_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_unit #(.SIGNED(1)) u_dut_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_divisor_tdata   (b_data),
        .s_axis_dividend_tvalid (a_vld),
        .s_axis_divisor_tvalid  (b_vld),
        .s_axis_dividend_tready (s_rdy_a),
        .s_axis_divisor_tready  (s_rdy_b),
        .m_axis_dout_tdata      (s_data),
        .m_axis_dout_tvalid     (s_vld)
    );

    div_unit #(.SIGNED(0)) u_dut_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_divisor_tdata   (b_data),
        .s_axis_dividend_tvalid (a_vld),
        .s_axis_divisor_tvalid  (b_vld),
        .s_axis_dividend_tready (u_rdy_a),
        .s_axis_divisor_tready  (u_rdy_b),
        .m_axis_dout_tdata      (u_data),
        .m_axis_dout_tvalid     (u_vld)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One accept, then watch ncyc cycles; cycle k is sampled on the k-th negedge after accept.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int lat, input int ncyc,
                           output logic [63:0] s_res, output logic [63:0] u_res,
                           output int s_cyc, output int s_cnt, output int u_cyc, output int rdy_bad);
        @(negedge clk);
        a_data = a; b_data = b; a_vld = 1'b1; b_vld = 1'b1;
        @(posedge clk);
        #1;
        a_vld = 1'b0; b_vld = 1'b0;
        s_res = '0; u_res = '0; s_cyc = -1; s_cnt = 0; u_cyc = -1; rdy_bad = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (s_vld) begin s_cnt++; s_cyc = k; s_res = s_data; end
            if (u_vld) begin u_cyc = k; u_res = u_data; end
            if (s_rdy_a !== (k > lat) || s_rdy_b !== s_rdy_a || u_rdy_a !== u_rdy_b) rdy_bad++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] es;
        logic [63:0] eu;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [63:0] s_res, u_res;
        int s_cyc, s_cnt, u_cyc, rdy_bad, lat, pulses, c1, c2;
        logic [63:0] d1, d2;

        vecs[0] = '{32'd100,        32'd7,          {32'h0000000E, 32'h00000002}, {32'h0000000E, 32'h00000002}};
        vecs[1] = '{32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFD, 32'hFFFFFFFF}, {32'h7FFFFFFC, 32'h00000001}};
        vecs[2] = '{32'd7,          32'hFFFFFFFE,   {32'hFFFFFFFD, 32'h00000001}, {32'h00000000, 32'h00000007}};
        vecs[3] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   {32'h00000003, 32'hFFFFFFFF}, {32'h00000000, 32'hFFFFFFF9}};
        vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h00000000}, {32'h00000000, 32'h80000000}};
        vecs[5] = '{32'h80000000,   32'd1,          {32'h80000000, 32'h00000000}, {32'h80000000, 32'h00000000}};
        vecs[6] = '{32'hFFFFFFF9,   32'd0,          {32'h00000001, 32'hFFFFFFF9}, {32'hFFFFFFFF, 32'hFFFFFFF9}};
        vecs[7] = '{32'd1000000,    32'd3,          {32'h00051615, 32'h00000001}, {32'h00051615, 32'h00000001}};

        resetn = 1'b0; a_data = '0; b_data = '0; a_vld = 1'b0; b_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tready", {62'd0, s_rdy_a, s_rdy_b}, 64'd3);
        check_eq("reset_tvalid", {63'd0, s_vld}, 64'd0);
        check_eq("reset_tdata", s_data, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
`ifdef DIV_ZERO_FAST_EN
            lat = (vecs[i].b == 32'd0) ? 1 : 33;
`else
            lat = 33;
`endif
            run_div(vecs[i].a, vecs[i].b, lat, 40, s_res, u_res, s_cyc, s_cnt, u_cyc, rdy_bad);
            check_eq($sformatf("v%0d_signed_data", i), s_res, vecs[i].es);
            check_eq($sformatf("v%0d_unsigned_data", i), u_res, vecs[i].eu);
            check_eq($sformatf("v%0d_valid_cycle", i), 64'(s_cyc), 64'(lat));
            check_eq($sformatf("v%0d_unsigned_cycle", i), 64'(u_cyc), 64'(lat));
            check_eq($sformatf("v%0d_pulse_count", i), 64'(s_cnt), 64'd1);
            check_eq($sformatf("v%0d_tready_profile", i), 64'(rdy_bad), 64'd0);
        end

        // Back-to-back with both tvalids held high
        @(negedge clk);
        a_data = 32'd100; b_data = 32'd7; a_vld = 1'b1; b_vld = 1'b1;
        @(posedge clk);
        #1;
        a_data = 32'hFFFFFFF9; b_data = 32'd2;
        pulses = 0; c1 = -1; c2 = -1; d1 = '0; d2 = '0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 40) begin a_vld = 1'b0; b_vld = 1'b0; end
            if (s_vld) begin
                pulses++;
                if (pulses == 1) begin c1 = k; d1 = s_data; end
                else begin c2 = k; d2 = s_data; end
            end
        end
        check_eq("b2b_pulses", 64'(pulses), 64'd2);
        check_eq("b2b_first_cycle", 64'(c1), 64'd33);
        check_eq("b2b_second_cycle", 64'(c2), 64'd67);
        check_eq("b2b_first_data", d1, {32'h0000000E, 32'h00000002});
        check_eq("b2b_second_data", d2, {32'hFFFFFFFD, 32'hFFFFFFFF});

        // Only the dividend side valid: no accept
        @(negedge clk);
        a_data = 32'd50; b_data = 32'd5; a_vld = 1'b1; b_vld = 1'b0;
        pulses = 0; rdy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_vld) pulses++;
            if (s_rdy_a !== 1'b1) rdy_bad++;
        end
        a_vld = 1'b0;
        check_eq("single_valid_pulses", 64'(pulses), 64'd0);
        check_eq("single_valid_tready", 64'(rdy_bad), 64'd0);

        // Reset in the middle of a division
        @(negedge clk);
        a_data = 32'd100; b_data = 32'd7; a_vld = 1'b1; b_vld = 1'b1;
        @(posedge clk);
        #1;
        a_vld = 1'b0; b_vld = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (s_vld) pulses++;
        end
        resetn = 1'b0;
        @(negedge clk);
        check_eq("midrst_tready", {62'd0, s_rdy_a, s_rdy_b}, 64'd3);
        check_eq("midrst_tdata", s_data, 64'd0);
        check_eq("midrst_tvalid", {63'd0, s_vld}, 64'd0);
        resetn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_vld) pulses++;
        end
        check_eq("midrst_no_pulse", 64'(pulses), 64'd0);
        run_div(32'd1000000, 32'd3, 33, 40, s_res, u_res, s_cyc, s_cnt, u_cyc, rdy_bad);
        check_eq("post_rst_data", s_res, {32'h00051615, 32'h00000001});
        check_eq("post_rst_cycle", 64'(s_cyc), 64'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider that sits behind the ALU's divide path. It is the responder end of the ALU's AXI-stream-style divide handshake: it accepts a dividend/divisor pair, iterates for 32 cycles, and returns `{quotient, remainder}` with a one-cycle valid pulse. The execute stage instantiates two copies, one signed (`div`/`mod`) and one unsigned (`divu`/`modu`).

## Interface
- `SIGNED`, default 1: 1 = two's-complement operands, 0 = unsigned operands.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `s_axis_dividend_tdata`  in  32  dividend; sampled on accept.
- `s_axis_divisor_tdata`  in  32  divisor; sampled on accept.
- `s_axis_dividend_tvalid`  in  1  dividend valid.
- `s_axis_divisor_tvalid`  in  1  divisor valid.
- `s_axis_dividend_tready`  out  1  ready for a dividend.
- `s_axis_divisor_tready`  out  1  ready for a divisor; always equal to `s_axis_dividend_tready`.
- `m_axis_dout_tdata`  out  64  `[63:32]` = quotient, `[31:0]` = remainder.
- `m_axis_dout_tvalid`  out  1  result valid; one-cycle pulse, no back-pressure.

## Operation
- States: IDLE, CALC, DONE.
- Both tready outputs are asserted only in IDLE.
- **Accept** happens on a rising edge where state is IDLE and both tvalids are 1.
  - Latch the operand magnitudes. When `SIGNED`=1, take the absolute value of each operand and treat the divisor sign as 0 when the divisor is zero. When `SIGNED`=0, the magnitudes are the raw operands.
  - Latch `q_neg = sign(a) ^ sign(b)` and `r_neg = sign(a)`. Both are 0 when `SIGNED`=0.
  - Clear the 6-bit iteration counter and enter CALC.
- **A single tvalid high** is not an accept; the unit stays in IDLE.
- **CALC**, restoring algorithm, one quotient bit per cycle, MSB first.
  - Form a 33-bit trial value `{rem[31:0], dvd_msb} - {1'b0, dsr}`.
  - If the trial value is non-negative, the remainder takes it and the quotient bit is 1. Otherwise the remainder is the shifted value and the quotient bit is 0.
  - After 32 iterations, move to DONE.
- **DONE**
  - Register `tdata = {q_neg ? -q : q, r_neg ? -r : r}`.
  - Assert `m_axis_dout_tvalid` for exactly this one cycle, then return to IDLE.
- **Output hold:** `tdata` keeps its value until the next DONE.
- **Semantics**
  - The quotient truncates toward zero.
  - The remainder takes the dividend's sign.
  - All arithmetic is modulo 2^32.
- **Boundary results**
  - Divide by zero gives magnitude quotient 0xFFFFFFFF and remainder equal to the dividend magnitude, then the sign rules above are applied.
  - In signed mode, 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0.
  - In signed mode, 0x80000000 / 1 gives q = 0x80000000, r = 0.
- **Input changes mid-operation:** operand or tvalid changes during CALC or DONE are ignored.

## Timing
- **Reset** (`resetn`=0 at an edge): state IDLE, both tready = 1 after the edge, `m_axis_dout_tvalid` = 0, `m_axis_dout_tdata` = 0, counter = 0.
- **Reset mid-operation:** any in-flight division is discarded and no valid pulse is produced.
- **Latency:** with the accept edge ending cycle 0, CALC occupies cycles 1–32, DONE is cycle 33 (tvalid high), and IDLE resumes in cycle 34.
- **Throughput:** tready is low during cycles 1–33. With tvalids held high, the next accept occurs at the end of cycle 34, so throughput is one division per 34 cycles.
- **Handshake:** tvalid may rise in any cycle. There is no combinational path from tvalid to tready.

## Configuration
- **Macro:** `DIV_ZERO_FAST_EN`.
- **Defined:** an accept with divisor == 0 skips CALC and goes IDLE → DONE. tvalid rises in cycle 1 with the same result values as the full algorithm, and IDLE resumes in cycle 2.
- **Undefined:** divide by zero takes the full 33-cycle latency like any other operand pair.
- **Unaffected:** non-zero divisors behave identically in both builds.

## Test plan
- **Unsigned quotient/remainder:** `SIGNED`=0, 100 / 7 → tdata = {0x0000000E, 0x00000002}, tvalid exactly in cycle 33, tready low in cycles 1–33.
- **Signed sign rules:** `SIGNED`=1.
  - −7 / 2 → {0xFFFFFFFD, 0xFFFFFFFF}.
  - 7 / −2 → {0xFFFFFFFD, 0x00000001}.
  - −7 / −2 → {0x00000003, 0xFFFFFFFF}.
- **Signed overflow:** `SIGNED`=1, 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}.
- **Divide by zero:** `SIGNED`=1, −7 / 0 → {0x00000001, 0xFFFFFFF9}.
  - Without the macro, tvalid in cycle 33.
  - With `DIV_ZERO_FAST_EN`, tvalid in cycle 1.
- **Back-to-back and single valid:**
  - Hold both tvalids high across two operand sets; the second accept lands at the end of cycle 34 and its result appears in cycle 67.
  - Assert only dividend_tvalid; no accept occurs and tvalid never pulses.
- **Reset mid-operation:** drive `resetn` low at cycle 15 of a division → tvalid never pulses, tdata = 0, tready = 1 after the reset edge, and the next division completes correctly.
